// File: rtl/matmul_seq_ctrl.sv
// Address sequencer for the matmul accelerator: sweeps row/column addresses per core group,
// flags group starts, honours stall, and provides pipeline-aligned delayed copies of the beat.
module matmul_seq_ctrl #(
  parameter int ROWS       = 2,
  parameter int COLS       = 4,
  parameter int CORE_COUNT = 4,
  parameter int ADR_W      = 5,
  parameter int PIPE_DEPTH = 2
) (
  input  logic             CLOCK_25,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  output logic [ADR_W-1:0] column_adr,
  output logic [ADR_W-1:0] row_adr,
  output logic [ADR_W-1:0] core_column,
  output logic             adr_valid,
  output logic             core_clr,
  output logic [ADR_W-1:0] row_adr_d,
  output logic [ADR_W-1:0] core_column_d,
  output logic             adr_valid_d,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam int PW = 2 * ADR_W + 1;

  localparam logic [ADR_W:0]   L_COLS       = (ADR_W+1)'(COLS);
  localparam logic [ADR_W:0]   L_STEP       = (ADR_W+1)'(CORE_COUNT);
  localparam logic [ADR_W-1:0] L_COL_LAST   = ADR_W'(COLS - 1);
  localparam logic [ADR_W-1:0] L_ROW_LAST   = ADR_W'(ROWS - 1);
  localparam logic [ADR_W-1:0] L_ADR_ONE    = ADR_W'(1);
  localparam logic [DW-1:0]    L_DRAIN_LAST = DW'(PIPE_DEPTH - 1);
  localparam logic [DW-1:0]    L_DRAIN_ONE  = DW'(1);

  state_t           r_state;
  logic [ADR_W-1:0] r_col;
  logic [ADR_W-1:0] r_row;
  logic [ADR_W-1:0] r_core;
  logic [DW-1:0]    r_drain_cnt;
  logic [PW-1:0]    r_pipe [PIPE_DEPTH];

  state_t           w_state_next;
  logic [ADR_W-1:0] w_col_next;
  logic [ADR_W-1:0] w_row_next;
  logic [ADR_W-1:0] w_core_next;
  logic [DW-1:0]    w_drain_next;
  logic [ADR_W:0]   w_core_sum;
  logic             w_adr_valid;
  logic             w_core_clr;

  always_ff @(posedge CLOCK_25 or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_core      <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_col       <= w_col_next;
      r_row       <= w_row_next;
      r_core      <= w_core_next;
      r_drain_cnt <= w_drain_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_core_next  = r_core;
    w_drain_next = r_drain_cnt;
    w_adr_valid  = 1'b0;
    w_core_clr   = 1'b0;
    // Extra bit keeps the next-group test from wrapping near the top of the address range.
    w_core_sum   = {1'b0, r_core} + L_STEP;

    unique case (r_state)
      S_IDLE: begin
        w_col_next   = '0;
        w_row_next   = '0;
        w_core_next  = '0;
        w_drain_next = '0;
        if (start) begin
          w_state_next = S_DRAW;
        end
      end

      S_DRAW: begin
        if (!stall) begin
          w_adr_valid = 1'b1;
          w_core_clr  = (r_col == '0) && (r_row == '0);
          if (r_col != L_COL_LAST) begin
            w_col_next = r_col + L_ADR_ONE;
          end else begin
            w_col_next = '0;
            if (r_row != L_ROW_LAST) begin
              w_row_next = r_row + L_ADR_ONE;
            end else begin
              w_row_next = '0;
              if (w_core_sum < L_COLS) begin
                w_core_next = w_core_sum[ADR_W-1:0];
              end else begin
                w_state_next = S_DRAIN;
                w_drain_next = '0;
              end
            end
          end
        end
      end

      S_DRAIN: begin
        if (r_drain_cnt == L_DRAIN_LAST) begin
          w_state_next = S_DONE;
          w_drain_next = '0;
          w_core_next  = '0;
        end else begin
          w_drain_next = r_drain_cnt + L_DRAIN_ONE;
        end
      end

      S_DONE: begin
        w_col_next   = '0;
        w_row_next   = '0;
        w_core_next  = '0;
        w_drain_next = '0;
        if (!start) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Delay line runs every cycle so stalled (invalid) beats stay aligned with the core pipeline.
  always_ff @(posedge CLOCK_25 or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= {w_adr_valid, r_core, r_row};
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign column_adr    = r_col;
  assign row_adr       = r_row;
  assign core_column   = r_core;
  assign adr_valid     = w_adr_valid;
  assign core_clr      = w_core_clr;
  assign row_adr_d     = r_pipe[PIPE_DEPTH-1][ADR_W-1:0];
  assign core_column_d = r_pipe[PIPE_DEPTH-1][2*ADR_W-1:ADR_W];
  assign adr_valid_d   = r_pipe[PIPE_DEPTH-1][2*ADR_W];
  assign busy          = (r_state == S_DRAW) || (r_state == S_DRAIN);
  assign done          = (r_state == S_DONE);
  assign state         = r_state;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: three configurations share stimulus; each is checked every cycle
// against a beat-list / timeline reference model.
module tb_matmul_seq_ctrl;

  localparam int N  = 3;
  localparam int AW = 5;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;

  logic [AW-1:0] col_o   [N];
  logic [AW-1:0] row_o   [N];
  logic [AW-1:0] cc_o    [N];
  logic [AW-1:0] row_d_o [N];
  logic [AW-1:0] cc_d_o  [N];
  logic          valid_o [N];
  logic          clr_o   [N];
  logic          valid_d_o [N];
  logic          busy_o  [N];
  logic          done_o  [N];
  logic [1:0]    state_o [N];

  always #20 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    matmul_seq_ctrl #(
      .ROWS(2),
      .COLS(gi == 1 ? 8 : (gi == 2 ? 6 : 4)),
      .CORE_COUNT(4),
      .ADR_W(AW),
      .PIPE_DEPTH(gi == 2 ? 3 : 2)
    ) u_dut (
      .CLOCK_25(clk),
      .rst(rst),
      .start(start),
      .stall(stall),
      .column_adr(col_o[gi]),
      .row_adr(row_o[gi]),
      .core_column(cc_o[gi]),
      .adr_valid(valid_o[gi]),
      .core_clr(clr_o[gi]),
      .row_adr_d(row_d_o[gi]),
      .core_column_d(cc_d_o[gi]),
      .adr_valid_d(valid_d_o[gi]),
      .busy(busy_o[gi]),
      .done(done_o[gi]),
      .state(state_o[gi])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model: 0 idle, 1 issuing beats, 2 draining, 3 done.
  int m_st [N];
  int m_idx [N];
  int m_nb [N];
  int m_dcnt [N];
  int m_last_cc [N];
  int b_row [N][64];
  int b_col [N][64];
  int b_cc  [N][64];
  int h_v   [N][4];
  int h_row [N][4];
  int h_cc  [N][4];
  int cur_v [N];
  int cur_row [N];
  int cur_cc [N];
  int obs_beats [N];
  int obs_clr [N];
  int obs_draw [N];

  function automatic int cols_of(input int k);
    return (k == 1) ? 8 : ((k == 2) ? 6 : 4);
  endfunction

  function automatic int pd_of(input int k);
    return (k == 2) ? 3 : 2;
  endfunction

  function automatic int groups_of(input int k);
    return (cols_of(k) + 3) / 4;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_beats(input int k);
    m_nb[k]  = 0;
    m_idx[k] = 0;
    for (int cc = 0; cc < cols_of(k); cc += 4) begin
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < cols_of(k); c++) begin
          b_row[k][m_nb[k]] = r;
          b_col[k][m_nb[k]] = c;
          b_cc[k][m_nb[k]]  = cc;
          m_nb[k]++;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_st[k] = 0; m_idx[k] = 0; m_nb[k] = 0; m_dcnt[k] = 0; m_last_cc[k] = 0;
      for (int i = 0; i < 4; i++) begin
        h_v[k][i] = 0; h_row[k][i] = 0; h_cc[k][i] = 0;
      end
    end
  endtask

  task automatic clear_obs();
    for (int k = 0; k < N; k++) begin
      obs_beats[k] = 0; obs_clr[k] = 0; obs_draw[k] = 0;
    end
  endtask

  task automatic check_all();
    int ecol, erow, ecc, ev, eclr, pd;
    for (int k = 0; k < N; k++) begin
      pd = pd_of(k);
      ecol = 0; erow = 0; ecc = 0;
      if (m_st[k] == 1) begin
        ecol = b_col[k][m_idx[k]];
        erow = b_row[k][m_idx[k]];
        ecc  = b_cc[k][m_idx[k]];
      end else if (m_st[k] == 2) begin
        ecc = m_last_cc[k];
      end
      ev   = (m_st[k] == 1 && !stall) ? 1 : 0;
      eclr = (ev == 1 && ecol == 0 && erow == 0) ? 1 : 0;
      cur_v[k] = ev; cur_row[k] = erow; cur_cc[k] = ecc;
      check_value($sformatf("i%0d state", k), state_o[k], m_st[k]);
      check_value($sformatf("i%0d column_adr", k), col_o[k], ecol);
      check_value($sformatf("i%0d row_adr", k), row_o[k], erow);
      check_value($sformatf("i%0d core_column", k), cc_o[k], ecc);
      check_value($sformatf("i%0d adr_valid", k), valid_o[k], ev);
      check_value($sformatf("i%0d core_clr", k), clr_o[k], eclr);
      check_value($sformatf("i%0d busy", k), busy_o[k], (m_st[k] == 1 || m_st[k] == 2) ? 1 : 0);
      check_value($sformatf("i%0d done", k), done_o[k], (m_st[k] == 3) ? 1 : 0);
      check_value($sformatf("i%0d adr_valid_d", k), valid_d_o[k], h_v[k][pd-1]);
      check_value($sformatf("i%0d row_adr_d", k), row_d_o[k], h_row[k][pd-1]);
      check_value($sformatf("i%0d core_column_d", k), cc_d_o[k], h_cc[k][pd-1]);
      if (valid_o[k] === 1'b1) obs_beats[k]++;
      if (clr_o[k] === 1'b1) obs_clr[k]++;
      if (state_o[k] === 2'd1) obs_draw[k]++;
    end
  endtask

  task automatic advance();
    int pd;
    for (int k = 0; k < N; k++) begin
      pd = pd_of(k);
      for (int i = pd - 1; i > 0; i--) begin
        h_v[k][i] = h_v[k][i-1]; h_row[k][i] = h_row[k][i-1]; h_cc[k][i] = h_cc[k][i-1];
      end
      h_v[k][0] = cur_v[k]; h_row[k][0] = cur_row[k]; h_cc[k][0] = cur_cc[k];
      case (m_st[k])
        0: if (start) begin m_st[k] = 1; build_beats(k); end
        1: if (!stall) begin
          m_last_cc[k] = b_cc[k][m_idx[k]];
          m_idx[k]++;
          if (m_idx[k] == m_nb[k]) begin m_st[k] = 2; m_dcnt[k] = 0; end
        end
        2: begin m_dcnt[k]++; if (m_dcnt[k] == pd) m_st[k] = 3; end
        default: if (!start) m_st[k] = 0;
      endcase
    end
  endtask

  task automatic step(input logic s_start, input logic s_stall, input logic s_rst);
    @(negedge clk);
    rst   = s_rst;
    start = s_start;
    stall = s_stall;
    #1;
    if (!rst) model_reset();
    check_all();
    if (rst) advance();
  endtask

  task automatic check_run_totals(input string ph);
    for (int k = 0; k < N; k++) begin
      check_value($sformatf("%s i%0d beats", ph, k), obs_beats[k], 2 * cols_of(k) * groups_of(k));
      check_value($sformatf("%s i%0d core_clr count", ph, k), obs_clr[k], groups_of(k));
    end
  endtask

  initial begin
    int scnt, lidx;
    logic s;

    model_reset();
    #1;
    check_all();
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // Plain run from a one-cycle start pulse.
    clear_obs();
    step(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 50; c++) step(1'b0, 1'b0, 1'b1);
    check_run_totals("plain");

    // Stall instance 0 on its beats 0 and 5 for three cycles each.
    clear_obs();
    scnt = 0;
    lidx = -1;
    step(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 60; c++) begin
      if (m_idx[0] != lidx) begin lidx = m_idx[0]; scnt = 0; end
      s = (m_st[0] == 1) && (m_idx[0] == 0 || m_idx[0] == 5) && (scnt < 3);
      if (s) scnt++;
      step(1'b0, s, 1'b1);
    end
    check_run_totals("stall");
    for (int k = 0; k < N; k++) begin
      check_value($sformatf("stall i%0d draw cycles", k), obs_draw[k], 2 * cols_of(k) * groups_of(k) + 6);
    end

    // Start held high with random stalls: one run each, then hold in DONE.
    clear_obs();
    for (int c = 0; c < 120; c++) step(1'b1, ($urandom_range(0, 3) == 0), 1'b1);
    check_run_totals("held");
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a DRAW cycle.
    step(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 1'b1);
    #5;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Random start/stall traffic with one synchronous-window reset.
    for (int c = 0; c < 300; c++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), (c != 150));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
